// File: rtl/ram_1rw_arb.sv
// Round-robin arbiter that shares one single-port RAM (1-cycle read latency) among N_PORTS requesters.
// Latency: grant/req_ready and the RAM drive are combinational; read data returns on rsp_* one cycle after acceptance.
// Backpressure: a requester that is not granted sees req_ready low and holds its command; responses cannot be stalled.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-port command handshake (req_ready one-hot or zero)
//   req_we/req_addr/req_w_data per-port command fields
//   rsp_valid/rsp_r_data       per-port read response strobe, shared read data
//   ram_we/ram_addr/ram_w_data RAM command port (all zero when nothing is granted)
//   ram_r_data                 RAM read data, one cycle after the read address
module ram_1rw_arb #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int N_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             req_valid,
  output logic [N_PORTS-1:0]             req_ready,
  input  logic [N_PORTS-1:0]             req_we,
  input  logic [N_PORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [N_PORTS-1:0][DATA_W-1:0] req_w_data,
  output logic [N_PORTS-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_r_data,
  output logic                           ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_w_data,
  input  logic [DATA_W-1:0]              ram_r_data
);

  localparam int PTR_W = $clog2(N_PORTS);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0] rd_id_q, rd_id_d;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_id;
  logic [PTR_W-1:0] cand;

  // (a + b) mod N_PORTS for a < N_PORTS and 0 <= b <= N_PORTS, so one
  // conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_PORTS) s = s - N_PORTS;
    return PTR_W'(s);
  endfunction

  // Search ptr, ptr+1, ... (wrapping) and take the first valid requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Next state: pointer moves past the winner, holds when idle.
  always_comb begin
    ptr_d     = gnt_vld ? wrap_add(gnt_id, 1) : ptr_q;
    rd_pend_d = gnt_vld && !req_we[gnt_id];
    rd_id_d   = rd_pend_d ? gnt_id : rd_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // RAM command mux; everything is forced to zero with no grant so the
  // RAM sees a clean idle bus.
  always_comb begin
    req_ready  = '0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      ram_we            = req_we[gnt_id];
      ram_addr          = req_addr[gnt_id];
      ram_w_data        = req_w_data[gnt_id];
    end
  end

  // Read data is steered only by the strobe; the data bus is shared.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      rsp_valid[i] = rd_pend_q && (rd_id_q == PTR_W'(i));
    end
  end

  assign rsp_r_data = ram_r_data;

endmodule

// File: tb/tb_ram_1rw_arb.sv
module tb_ram_1rw_arb;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int N_PORTS = 2;

  logic                           clk;
  logic                           rst_n;
  logic [N_PORTS-1:0]             req_valid;
  logic [N_PORTS-1:0]             req_ready;
  logic [N_PORTS-1:0]             req_we;
  logic [N_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [N_PORTS-1:0][DATA_W-1:0] req_w_data;
  logic [N_PORTS-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_r_data;
  logic                           ram_we;
  logic [ADDR_W-1:0]              ram_addr;
  logic [DATA_W-1:0]              ram_w_data;
  logic [DATA_W-1:0]              ram_r_data;

  int n_chk;
  int n_err;

  // Expected RAM contents, maintained by hand alongside the stimulus.
  logic [DATA_W-1:0] em [DEPTH];

  ram_1rw_arb #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .N_PORTS(N_PORTS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_w_data(req_w_data),
    .rsp_valid (rsp_valid),
    .rsp_r_data(rsp_r_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data)
  );

  // Behavioural single-port RAM: write at the edge, registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    rst_n = 1'b1;

    // Preload: lone port 0 writes every address back-to-back.
    for (int a = 0; a < DEPTH; a++) begin
      if (a > 0) tick();
      req_valid     = 2'b01;
      req_we        = 2'b01;
      req_addr[0]   = ADDR_W'(a);
      req_w_data[0] = DATA_W'(32'h1000 + a);
      em[a]         = DATA_W'(32'h1000 + a);
      #2;
      chk("pre_ready", 32'(req_ready), 32'h1);
      chk("pre_we", 32'(ram_we), 32'h1);
      chk("pre_addr", 32'(ram_addr), 32'(a));
    end

    // Write then read-after-write from port 0.
    tick();
    req_addr[0] = 4'd3; req_w_data[0] = 16'hA5A5; em[3] = 16'hA5A5;
    #2;
    chk("raw_wr_ready", 32'(req_ready), 32'h1);
    chk("raw_wr_data", 32'(ram_w_data), 32'hA5A5);
    tick();
    req_we = 2'b00;
    #2;
    chk("raw_rd_ready", 32'(req_ready), 32'h1);
    chk("raw_rd_ram_we", 32'(ram_we), 32'h0);
    chk("raw_no_rsp_for_wr", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 2'b00;
    #2;
    chk("raw_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("raw_rsp_data", 32'(rsp_r_data), 32'hA5A5);

    // Port 1 writes, port 0 reads the same address next cycle.
    tick();
    req_valid = 2'b10; req_we = 2'b10;
    req_addr[1] = 4'd7; req_w_data[1] = 16'h1234; em[7] = 16'h1234;
    #2;
    chk("x_wr_ready", 32'(req_ready), 32'h2);
    chk("x_wr_addr", 32'(ram_addr), 32'h7);
    chk("x_wr_data", 32'(ram_w_data), 32'h1234);
    tick();
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 4'd7;
    #2;
    chk("x_rd_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #2;
    chk("x_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("x_rsp_data", 32'(rsp_r_data), 32'h1234);

    // Fairness from reset: both ports read continuously.
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 4'd1; req_addr[1] = 4'd2;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      if (c == 6) req_valid = 2'b00;
      #2;
      if (c < 6) begin
        chk("rr_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_addr", 32'(ram_addr), (c % 2 == 0) ? 32'h1 : 32'h2);
      end
      if (c > 0) begin
        chk("rr_rsp_valid", 32'(rsp_valid), ((c - 1) % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_rsp_data", 32'(rsp_r_data), 32'(((c - 1) % 2 == 0) ? em[1] : em[2]));
      end
    end

    // Lone port 0 streams 16 reads with no bubbles.
    for (int c = 0; c <= DEPTH; c++) begin
      tick();
      if (c < DEPTH) begin
        req_valid = 2'b01; req_we = 2'b00; req_addr[0] = ADDR_W'(c);
      end else begin
        req_valid = 2'b00;
      end
      #2;
      if (c < DEPTH) chk("seq_ready", 32'(req_ready), 32'h1);
      if (c > 0) begin
        chk("seq_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("seq_rsp_data", 32'(rsp_r_data), 32'(em[c - 1]));
      end
    end

    // Grant port 0, idle 3 cycles, then both valid: port 1 wins.
    tick();
    req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 4'd9; req_w_data[0] = 16'hBEEF; em[9] = 16'hBEEF;
    #2;
    chk("hold_wr_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      req_valid = 2'b00;
      #2;
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_ram_we", 32'(ram_we), 32'h0);
      chk("idle_ram_addr", 32'(ram_addr), 32'h0);
      chk("idle_ram_wdata", 32'(ram_w_data), 32'h0);
      chk("idle_rsp", 32'(rsp_valid), 32'h0);
    end
    tick();
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 4'd0; req_addr[1] = 4'd9;
    #2;
    chk("hold_first_gnt", 32'(req_ready), 32'h2);
    chk("hold_first_addr", 32'(ram_addr), 32'h9);
    tick();
    req_valid = 2'b01;
    #2;
    chk("hold_second_gnt", 32'(req_ready), 32'h1);
    chk("hold_rsp1_valid", 32'(rsp_valid), 32'h2);
    chk("hold_rsp1_data", 32'(rsp_r_data), 32'hBEEF);
    tick();
    req_valid = 2'b00;
    #2;
    chk("hold_rsp0_valid", 32'(rsp_valid), 32'h1);
    chk("hold_rsp0_data", 32'(rsp_r_data), 32'(em[0]));

    // Read accepted, then reset mid next cycle: response dropped, ptr cleared.
    tick();
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 4'd5;
    #2;
    chk("drop_rd_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    chk("drop_rsp_now", 32'(rsp_valid), 32'h0);
    tick();
    #2;
    chk("drop_rsp_after", 32'(rsp_valid), 32'h0);
    chk("drop_ready_rst", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    tick();
    req_valid = 2'b11; req_addr[0] = 4'd4; req_addr[1] = 4'd6;
    #2;
    chk("post_rst_gnt", 32'(req_ready), 32'h1);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 2'b00;
    #2;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rsp_data", 32'(rsp_r_data), 32'(em[4]));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_1rw_arb.md
# ram_1rw_arb

Round-robin arbiter sharing one `ram_1rw` single-port RAM between `N_PORTS` requesters. Each requester issues read or write commands over a valid/ready handshake. The arbiter grants at most one command per cycle and drives the RAM port. It routes the 1-cycle-latency read data back to the requester that issued the read. It sits between client blocks and the RAM instance, and lets the RAM run at one access per clock under contention.

## Interface
Parameters:
- `DATA_W`, 16, RAM word width; passed through to `ram_1rw`.
- `DEPTH`, 16, RAM word count.
- `ADDR_W`, `$clog2(DEPTH)`, address width (derived).
- `N_PORTS`, 2, number of requesters; legal range 2..8.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, `[N_PORTS]`: requester i presents a command.
- `req_ready`, out, `[N_PORTS]`: command of requester i is accepted this cycle.
- `req_we`, in, `[N_PORTS]`: 1 = write, 0 = read.
- `req_addr`, in, `[N_PORTS][ADDR_W]`: command address.
- `req_w_data`, in, `[N_PORTS][DATA_W]`: write data; ignored for reads.
- `rsp_valid`, out, `[N_PORTS]`: read data for requester i is on `rsp_r_data`.
- `rsp_r_data`, out, `DATA_W`: read data, shared by all requesters, qualified by `rsp_valid`.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, `ADDR_W`: RAM address.
- `ram_w_data`, out, `DATA_W`: RAM write data.
- `ram_r_data`, in, `DATA_W`: RAM read data, valid one cycle after a read address is presented.

## Operation
Priority pointer `ptr`:
- Register of width `$clog2(N_PORTS)`.
- Reset value 0.

Grant:
- Combinational from `req_valid` and `ptr`.
- Grant goes to the first requester with `req_valid` set, searching `ptr`, `ptr+1`, …, wrapping modulo `N_PORTS`.
- `req_ready` is one-hot (granted port) or all-zero (no valid request).
- `req_ready[i]` never asserts without `req_valid[i]`.

Handshake:
- A command transfers when `req_valid[i] && req_ready[i]`.
- A requester holds `req_valid`, `req_we`, `req_addr` and `req_w_data` stable until ready. The arbiter does not check this.

RAM drive:
- `ram_addr` and `ram_w_data` are muxed combinationally from the granted port.
- `ram_we` = granted `req_we`.
- With no grant: `ram_we` = 0, and `ram_addr`/`ram_w_data` = 0.

Pointer update, on each rising edge:
- With a grant to port g: `ptr` ← (g+1) mod `N_PORTS`.
- With no grant: `ptr` holds.

Read tracking:
- On a granted read, register `rd_pend` = 1 and `rd_id` = g.
- Otherwise `rd_pend` = 0.
- `rsp_valid[i]` = `rd_pend && rd_id == i`.
- `rsp_r_data` = `ram_r_data` (combinational pass-through).
- When `rsp_valid` is all-zero, `rsp_r_data` is don't-care.

Writes produce no response.

There is no response backpressure: a requester must accept `rsp_valid` in the cycle it is asserted.

Reset:
- Asserting `rst_n` low at any time clears `ptr`, `rd_pend` and `rd_id` immediately.
- A read accepted in the cycle before reset gets no response; it is dropped.
- Commands not yet accepted are unaffected; requesters re-present them after reset.

## Timing
- Reset values: `rsp_valid` = 0, `req_ready` = 0 (with `req_valid` = 0), `ram_we` = 0.
- Grant and `req_ready` have zero latency: same cycle as `req_valid`.
- The write is committed at the rising edge ending the accept cycle T.
- Read accepted in cycle T gives `rsp_valid` and data in cycle T+1.
- Throughput: one command per cycle aggregate, with no bubbles between back-to-back commands from the same or different ports.
- Read-after-write: a write accepted at T followed by a read of the same address at T+1, from any port, returns the new data at T+2.
- Fairness: with all ports continuously valid, grants rotate 0,1,…,N−1,0,… Any continuously valid requester waits at most `N_PORTS`−1 cycles.
- A lone valid requester is granted every cycle, regardless of `ptr`.

## Test plan
- Port 0 writes 0xA5A5 to addr 3 at T, then reads addr 3 at T+1 -> `rsp_valid[0]` at T+2 with `rsp_r_data` = 0xA5A5; `rsp_valid[1]` stays 0.
- Both ports assert reads (port 0 addr 1, port 1 addr 2) continuously from reset, 6 cycles -> grants 0,1,0,1,0,1. Each `rsp_valid` is one-hot to the prior grantee with that address's data.
- Port 1 writes 0x1234 to addr 7 at T; port 0 reads addr 7 at T+1 -> `rsp_valid[0]` at T+2 with 0x1234.
- Port 0 alone issues reads of addrs 0..15 back-to-back -> `req_ready[0]` high for 16 consecutive cycles, and 16 consecutive `rsp_valid[0]` pulses with the matching data.
- Grant to port 0, then 3 idle cycles, then both ports valid -> port 1 granted first, showing `ptr` held through idle.
- Read accepted at T, `rst_n` pulsed low mid-cycle T+1 -> `rsp_valid` = 0 at T+1 and after. After release, both ports valid -> port 0 granted first.
